// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source count, id width,
// the "no source" id and the request/service state machine encoding.
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 4;

  // Id reported when no source is requested or in service.
  localparam logic [ID_W-1:0] ID_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

endpackage : irq_pkg

// File: rtl/irq_ctrl_ms_bit.sv
// Most-significant-set-bit encoder: returns the index of the highest set
// input bit, or ID_NONE when the input vector is all zeros.
module ms_bit
  import irq_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]  vec_i,
  output logic [OUT_W-1:0] idx_o
);

  // Scan upward so the highest set bit is the last one to overwrite idx_o.
  always_comb begin
    idx_o = ID_NONE;
    for (int i = 0; i < IN_W; i++) begin
      if (vec_i[i]) begin
        idx_o = OUT_W'(i);
      end
    end
  end

endmodule : ms_bit

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller. Rising edges on src set sticky pending
// bits; the highest unmasked pending source is offered on irq/irq_id and
// held until acknowledged, then tracked as in service until eoi.
// Every output comes straight from a register.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_data,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             ack,
  input  logic             eoi,
  output logic             busy
);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] src_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mask_d;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] cand;
  logic [ID_W-1:0]  sel_id;

  state_e           state_q;
  logic [ID_W-1:0]  cur_id_q;
  logic             irq_q;
  logic [ID_W-1:0]  irq_id_q;
  logic             busy_q;

  // Edge detect, pending set/clear and mask update; a new edge beats an ack clear.
  always_comb begin
    src_d  = src;
    rise   = src & ~src_q;
    clr    = '0;
    if (state_q == ST_REQ && ack) begin
      clr = N_SRC'(1) << cur_id_q;
    end
    pend_d = (pend_q & ~clr) | rise;
    mask_d = mask_wr ? mask_data : mask_q;
  end

  // Only unmasked pending sources compete; masked ones stay pending.
  assign cand = pend_q & mask_q;

  ms_bit #(
    .IN_W  (N_SRC),
    .OUT_W (ID_W)
  ) u_ms_bit (
    .vec_i (cand),
    .idx_o (sel_id)
  );

  // Source sampling, mask and pending registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  // Request/service sequencer with registered outputs; the offered id is
  // frozen in REQ so neither higher-priority arrivals nor mask writes can
  // change or withdraw it before ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_id_q <= ID_NONE;
      irq_q    <= 1'b0;
      irq_id_q <= ID_NONE;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|cand) begin
            state_q  <= ST_REQ;
            cur_id_q <= sel_id;
            irq_q    <= 1'b1;
            irq_id_q <= sel_id;
            busy_q   <= 1'b0;
          end
        end
        ST_REQ: begin
          // eoi alongside ack is ignored: only ack matters here.
          if (ack) begin
            state_q  <= ST_SERV;
            irq_q    <= 1'b0;
            irq_id_q <= cur_id_q;
            busy_q   <= 1'b1;
          end
        end
        ST_SERV: begin
          if (eoi) begin
            state_q  <= ST_IDLE;
            cur_id_q <= ID_NONE;
            irq_q    <= 1'b0;
            irq_id_q <= ID_NONE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          cur_id_q <= ID_NONE;
          irq_q    <= 1'b0;
          irq_id_q <= ID_NONE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mask    = mask_q;
  assign pending = pend_q;
  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign busy    = busy_q;

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a table of per-cycle inputs with the outputs expected
// after the following rising edge, run through a scoreboard queue, plus
// hand-written reset sequences.
module tb_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] src;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic [7:0] mask;
  logic [7:0] pending;
  logic       irq;
  logic [3:0] irq_id;
  logic       ack;
  logic       eoi;
  logic       busy;

  int total;
  int bad;

  typedef struct {
    logic [7:0] src;
    logic       mwr;
    logic [7:0] mdata;
    logic       ack;
    logic       eoi;
    logic       rst;
    logic       e_irq;
    logic [3:0] e_id;
    logic       e_busy;
    logic [7:0] e_pend;
    logic [7:0] e_mask;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  irq_ctrl #(
    .N_SRC (8),
    .ID_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .mask      (mask),
    .pending   (pending),
    .irq       (irq),
    .irq_id    (irq_id),
    .ack       (ack),
    .eoi       (eoi),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [7:0] s, logic w, logic [7:0] d, logic a,
                              logic e, logic r, logic ei, logic [3:0] eid,
                              logic eb, logic [7:0] ep, logic [7:0] em);
    vec_t v;
    v.src = s;  v.mwr = w;  v.mdata = d;  v.ack = a;  v.eoi = e;  v.rst = r;
    v.e_irq = ei;  v.e_id = eid;  v.e_busy = eb;  v.e_pend = ep;  v.e_mask = em;
    return v;
  endfunction

  task automatic chk(string nm, int row, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int row, logic ei, logic [3:0] eid,
                         logic eb, logic [7:0] ep, logic [7:0] em);
    chk({tag, ".irq"},     row, {7'd0, irq},    {7'd0, ei});
    chk({tag, ".irq_id"},  row, {4'd0, irq_id}, {4'd0, eid});
    chk({tag, ".busy"},    row, {7'd0, busy},   {7'd0, eb});
    chk({tag, ".pending"}, row, pending,        ep);
    chk({tag, ".mask"},    row, mask,           em);
  endtask

  initial begin
    vec_t e;
    total = 0;
    bad   = 0;

    // Columns: src mwr mdata ack eoi rst | irq id busy pending mask
    // Release from reset with all sources high and mask opened.
    tbl.push_back(mk(8'hFF,1,8'hFF,0,0,0, 0,4'hF,0,8'hFF,8'hFF));
    tbl.push_back(mk(8'hFF,0,8'h00,0,0,0, 1,4'h7,0,8'hFF,8'hFF));
    tbl.push_back(mk(8'hFF,0,8'h00,1,0,0, 0,4'h7,1,8'h7F,8'hFF));
    tbl.push_back(mk(8'hFF,0,8'h00,0,1,0, 0,4'hF,0,8'h7F,8'hFF));
    tbl.push_back(mk(8'hFF,0,8'h00,0,0,0, 1,4'h6,0,8'h7F,8'hFF));
    // eoi while requesting is ignored, then ack, then ack while serving ignored.
    tbl.push_back(mk(8'hFF,0,8'h00,0,1,0, 1,4'h6,0,8'h7F,8'hFF));
    tbl.push_back(mk(8'hFF,0,8'h00,1,0,0, 0,4'h6,1,8'h3F,8'hFF));
    tbl.push_back(mk(8'hFF,0,8'h00,1,0,0, 0,4'h6,1,8'h3F,8'hFF));
    // Reset during service abandons it.
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,4'hF,0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,1,8'hFF,0,0,0, 0,4'hF,0,8'h00,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1,0,0, 0,4'hF,0,8'h00,8'hFF));
    // Priority: sources 2 and 5 together, 5 first then 2.
    tbl.push_back(mk(8'h24,0,8'h00,0,0,0, 0,4'hF,0,8'h24,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h5,0,8'h24,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1,0,0, 0,4'h5,1,8'h04,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,4'hF,0,8'h04,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h2,0,8'h04,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1,0,0, 0,4'h2,1,8'h00,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,4'hF,0,8'h00,8'hFF));
    // No preemption: 6 arrives while 3 is requested.
    tbl.push_back(mk(8'h08,0,8'h00,0,0,0, 0,4'hF,0,8'h08,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h3,0,8'h08,8'hFF));
    tbl.push_back(mk(8'h40,0,8'h00,0,0,0, 1,4'h3,0,8'h48,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h3,0,8'h48,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1,0,0, 0,4'h3,1,8'h40,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,4'hF,0,8'h40,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h6,0,8'h40,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1,0,0, 0,4'h6,1,8'h00,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,4'hF,0,8'h00,8'hFF));
    // Masking: 7 pends while masked, raised once unmasked; mask write in REQ does not withdraw.
    tbl.push_back(mk(8'h00,1,8'h0F,0,0,0, 0,4'hF,0,8'h00,8'h0F));
    tbl.push_back(mk(8'h80,0,8'h00,0,0,0, 0,4'hF,0,8'h80,8'h0F));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 0,4'hF,0,8'h80,8'h0F));
    tbl.push_back(mk(8'h00,1,8'h80,0,0,0, 0,4'hF,0,8'h80,8'h80));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h7,0,8'h80,8'h80));
    tbl.push_back(mk(8'h00,1,8'h00,0,0,0, 1,4'h7,0,8'h80,8'h00));
    tbl.push_back(mk(8'h00,0,8'h00,1,0,0, 0,4'h7,1,8'h00,8'h00));
    tbl.push_back(mk(8'h00,1,8'hFF,0,1,0, 0,4'hF,0,8'h00,8'hFF));
    // Collision: new edge on 4 together with its ack keeps it pending.
    tbl.push_back(mk(8'h10,0,8'h00,0,0,0, 0,4'hF,0,8'h10,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h4,0,8'h10,8'hFF));
    tbl.push_back(mk(8'h10,0,8'h00,1,0,0, 0,4'h4,1,8'h10,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,4'hF,0,8'h10,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h4,0,8'h10,8'hFF));
    // ack and eoi together in REQ act as ack only.
    tbl.push_back(mk(8'h00,0,8'h00,1,1,0, 0,4'h4,1,8'h00,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,4'hF,0,8'h00,8'hFF));
    // Reset during REQ leaves nothing pending.
    tbl.push_back(mk(8'h02,0,8'h00,0,0,0, 0,4'hF,0,8'h02,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,4'h1,0,8'h02,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,4'hF,0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 0,4'hF,0,8'h00,8'h00));

    // Hold reset with all sources high: outputs must sit at reset values.
    rst_n = 1'b0;  src = 8'hFF;  mask_wr = 1'b1;  mask_data = 8'hFF;
    ack = 1'b0;  eoi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", -1, 1'b0, 4'hF, 1'b0, 8'h00, 8'h00);

    // Table: drive at the falling edge, expect after the next rising edge.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n     = ~tbl[i].rst;
      src       = tbl[i].src;
      mask_wr   = tbl[i].mwr;
      mask_data = tbl[i].mdata;
      ack       = tbl[i].ack;
      eoi       = tbl[i].eoi;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_all("vec", i, e.e_irq, e.e_id, e.e_busy, e.e_pend, e.e_mask);
    end

    // Asynchronous reset between clock edges while a request is up.
    @(negedge clk);
    rst_n = 1'b1;  src = 8'h01;  mask_wr = 1'b1;  mask_data = 8'hFF;
    ack = 1'b0;  eoi = 1'b0;
    @(negedge clk);
    src = 8'h00;  mask_wr = 1'b0;
    @(posedge clk);
    #1;
    chk_all("async_pre", 0, 1'b1, 4'h0, 1'b0, 8'h01, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1, 1'b0, 4'hF, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("async_post", 2, 1'b0, 4'hF, 1'b0, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_irq_ctrl
